// File: rtl/flt_rec_pkg.sv
// Shared definitions for the PNG scanline reconstruction engine.
`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif
`ifndef SIZE_W_WD
`define SIZE_W_WD (`LOG2(SIZE))
`endif

package flt_rec_pkg;

    localparam logic [7:0] FT_NONE  = 8'd0;
    localparam logic [7:0] FT_SUB   = 8'd1;
    localparam logic [7:0] FT_UP    = 8'd2;
    localparam logic [7:0] FT_AVG   = 8'd3;
    localparam logic [7:0] FT_PAETH = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TYPE,
        ST_DATA
    } state_e;

    function automatic logic [9:0] abs10(input logic signed [9:0] v);
        return (v < 0) ? -v : v;
    endfunction

    // Paeth predictor: choose the neighbour closest to a+b-c, ties to a then b.
    function automatic logic [7:0] paeth(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
        logic signed [9:0] sa, sb, sc, p;
        logic [9:0]        pa, pb, pc;
        sa = {2'b00, a};
        sb = {2'b00, b};
        sc = {2'b00, c};
        p  = sa + sb - sc;
        pa = abs10(p - sa);
        pb = abs10(p - sb);
        pc = abs10(p - sc);
        if (pa <= pb && pa <= pc) return a;
        else if (pb <= pc)        return b;
        else                      return c;
    endfunction

endpackage

// File: rtl/flt_rec_lbuf.sv
// Prior-row buffer: SIZE x 8 register array, one write port, one combinational read port.
module lbuf_rec
    import flt_rec_pkg::*;
#(
    parameter int unsigned SIZE = 2048
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [`SIZE_W_WD-1:0] wr_adr_i,
    input  logic [7:0]            wr_dat_i,
    input  logic [`SIZE_W_WD-1:0] rd_adr_i,
    output logic [7:0]            rd_dat_o
);

    logic [7:0] mem_q [SIZE];

    // Store the reconstructed byte of the current row for the next row to read.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_adr_i] <= wr_dat_i;
    end

    assign rd_dat_o = mem_q[rd_adr_i];

endmodule

// File: rtl/flt_rec.sv
// PNG scanline unfilter: filtered byte stream in, reconstructed raw bytes out.
module flt_rec
    import flt_rec_pkg::*;
#(
    parameter int unsigned SIZE    = 2048,
    parameter int unsigned BPP_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [`SIZE_W_WD-1:0] cfg_w_i,
    input  logic [15:0]           cfg_h_i,
    input  logic [3:0]            cfg_bpp_i,
    input  logic                  dat_val_i,
    input  logic [7:0]            dat_i,
    output logic                  dat_rdy_o,
    output logic                  rec_val_o,
    output logic [7:0]            rec_dat_o,
    input  logic                  rec_rdy_i,
    output logic                  rec_lst_o,
    output logic                  done_o,
    output logic                  err_o
);

    state_e                  state_q;
    logic [15:0]             row_q;
    logic [`SIZE_W_WD-1:0]   col_q;
    logic                    first_q;
    logic [7:0]              ftype_q;
    logic                    err_q;
    logic                    rec_val_q;
    logic [7:0]              rec_dat_q;
    logic                    rec_lst_q;
    logic                    done_q;
    logic [BPP_MAX-1:0][7:0] ahist_q;
    logic [BPP_MAX-1:0][7:0] chist_q;

    logic       adv, acc, acc_type, acc_data, last_col, last_row;
    logic [3:0] tap;
    logic [7:0] buf_rd, a_nb, b_nb, c_nb, pred, recon;
    logic [8:0] sum9;

    assign adv       = !rec_val_q || rec_rdy_i;
    assign dat_rdy_o = (state_q != ST_IDLE) && adv;
    assign acc       = dat_val_i && dat_rdy_o;
    assign acc_type  = acc && (state_q == ST_TYPE);
    assign acc_data  = acc && (state_q == ST_DATA);
    assign last_col  = (col_q == cfg_w_i);
    assign last_row  = (row_q == cfg_h_i);

    assign rec_val_o = rec_val_q;
    assign rec_dat_o = rec_dat_q;
    assign rec_lst_o = rec_lst_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

    lbuf_rec #(.SIZE(SIZE)) u_lbuf (
        .clk      (clk),
        .wr_en_i  (acc_data),
        .wr_adr_i (col_q),
        .wr_dat_i (recon),
        .rd_adr_i (col_q),
        .rd_dat_o (buf_rd)
    );

    // Neighbour selection and per-filter reconstruction of the incoming byte.
    always_comb begin
        tap = cfg_bpp_i - 4'd1;
        if (cfg_bpp_i == 4'd0)                 tap = 4'd0;
        else if (cfg_bpp_i > 4'(BPP_MAX))      tap = 4'(BPP_MAX - 1);
        a_nb = '0;
        c_nb = '0;
        for (int unsigned i = 0; i < BPP_MAX; i++) begin
            if (4'(i) == tap) begin
                a_nb = ahist_q[i];
                c_nb = chist_q[i];
            end
        end
        b_nb = first_q ? '0 : buf_rd;
        sum9 = {1'b0, a_nb} + {1'b0, b_nb};
        case (ftype_q)
            FT_SUB:   pred = a_nb;
            FT_UP:    pred = b_nb;
            FT_AVG:   pred = sum9[8:1];
            FT_PAETH: pred = paeth(a_nb, b_nb, c_nb);
            default:  pred = '0;
        endcase
        recon = dat_i + pred;
    end

    // Left-neighbour histories; emptied at each row start so x<bpp sees zeros.
    always_ff @(posedge clk) begin
        if (rst || acc_type) begin
            ahist_q <= '0;
            chist_q <= '0;
        end else if (acc_data) begin
            for (int unsigned i = BPP_MAX - 1; i > 0; i--) begin
                ahist_q[i] <= ahist_q[i-1];
                chist_q[i] <= chist_q[i-1];
            end
            ahist_q[0] <= recon;
            chist_q[0] <= b_nb;
        end
    end

    // Row/column FSM with registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            first_q   <= 1'b0;
            ftype_q   <= FT_NONE;
            err_q     <= 1'b0;
            rec_val_q <= 1'b0;
            rec_dat_q <= '0;
            rec_lst_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= rec_val_q && rec_rdy_i && rec_lst_q;
            if (adv) begin
                rec_val_q <= acc_data;
                rec_lst_q <= acc_data && last_col && last_row;
                if (acc_data) rec_dat_q <= recon;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_TYPE;
                        row_q   <= '0;
                        col_q   <= '0;
                        err_q   <= 1'b0;
                        first_q <= 1'b1;
                    end
                end
                ST_TYPE: begin
                    if (acc) begin
                        ftype_q <= dat_i;
                        if (dat_i > FT_PAETH) err_q <= 1'b1;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (acc) begin
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                state_q <= ST_IDLE;
                            end else begin
                                row_q   <= row_q + 16'd1;
                                first_q <= 1'b0;
                                state_q <= ST_TYPE;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
